// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM states and status-register layout for the SPI flash model.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_flash_pkg;

    localparam logic [7:0] CMD_RDID = 8'h9F;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_WRDI = 8'h04;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_PP   = 8'h02;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_RESP,
        ST_IGNORE
    } state_t;

    function automatic logic [7:0] status_byte(input logic wel, input logic wip);
        status_byte         = 8'h00;
        status_byte[SR_WEL] = wel;
        status_byte[SR_WIP] = wip;
    endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Two-flop synchroniser for the SPI pins plus SCK/CSB edge pulses.
// Latency: pin change to edge pulse is 3 clk.
// Backpressure: none; pulses are single-cycle and never held.
module spi_in_sync (
    input  logic clk,
    input  logic reset,
    input  logic spi_csb,
    input  logic spi_clk,
    input  logic spi_di,
    output logic csb_s,
    output logic di_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic csb_rise,
    output logic csb_fall
);

    logic [1:0] csb_ff;
    logic [1:0] sck_ff;
    logic [1:0] di_ff;
    logic       sck_prev;
    logic       csb_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csb_ff   <= 2'b11;
            sck_ff   <= 2'b00;
            di_ff    <= 2'b00;
            sck_prev <= 1'b0;
            csb_prev <= 1'b1;
        end else begin
            csb_ff   <= {csb_ff[0], spi_csb};
            sck_ff   <= {sck_ff[0], spi_clk};
            di_ff    <= {di_ff[0], spi_di};
            sck_prev <= sck_ff[1];
            csb_prev <= csb_ff[1];
        end
    end

    assign csb_s    = csb_ff[1];
    assign di_s     = di_ff[1];
    assign sck_rise = sck_ff[1] & ~sck_prev;
    assign sck_fall = ~sck_ff[1] & sck_prev;
    assign csb_rise = csb_ff[1] & ~csb_prev;
    assign csb_fall = ~csb_ff[1] & csb_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash model: RDID, RDSR, WREN, WRDI, READ, PP over a 2**AW byte array.
// Latency: DO updates within 4 clk of the SCK pin fall; status/opcode outputs 1 clk after the sync.
// Backpressure: none; the SPI master paces everything, busy is reported through WIP only.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int          AW          = 10,
    parameter int          BUSY_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_csb,
    input  logic       spi_clk,
    input  logic       spi_di,
    output logic       spi_do,
    output logic       wip,
    output logic       wel,
    output logic [7:0] cmd,
    output logic       cmd_strobe
);

    localparam int DEPTH = 1 << AW;
    localparam int BW    = $clog2(BUSY_CYCLES + 1);

    logic csb_s, di_s, sck_rise, sck_fall, csb_rise, csb_fall;

    spi_in_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .spi_csb  (spi_csb),
        .spi_clk  (spi_clk),
        .spi_di   (spi_di),
        .csb_s    (csb_s),
        .di_s     (di_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .csb_rise (csb_rise),
        .csb_fall (csb_fall)
    );

    // Array comes up erased at configuration and is deliberately never reset.
    logic [7:0] mem [DEPTH] = '{default: 8'hFF};

    state_t          state, state_n, disp_state;
    logic [2:0]      bit_cnt;
    logic [6:0]      shift_in;
    logic [4:0]      addr_cnt;
    logic [AW-1:0]   addr;
    logic [7:0]      tx_sr;
    logic [2:0]      tx_cnt;
    logic [1:0]      resp_idx;
    logic            resp_status, addr_is_read, pend_wren, pend_wrdi, pp_written;
    logic [BW-1:0]   busy_cnt;

    // An SCK edge seen together with (or after) CSB deassertion is dropped.
    logic          rise, fall, byte_done;
    logic [7:0]    rx_byte;
    logic [AW-1:0] addr_shift, addr_inc;

    assign rise       = sck_rise & ~csb_s;
    assign fall       = sck_fall & ~csb_s;
    assign rx_byte    = {shift_in, di_s};
    assign byte_done  = rise && (bit_cnt == 3'd7);
    assign addr_shift = {addr[AW-2:0], di_s};
    assign addr_inc   = addr + 1'b1;

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        disp_state = ST_IGNORE;
        if (wip) begin
            if (rx_byte == CMD_RDSR) disp_state = ST_RESP;
        end else begin
            case (rx_byte)
                CMD_RDID, CMD_RDSR: disp_state = ST_RESP;
                CMD_READ:           disp_state = ST_ADDR;
                CMD_PP:             disp_state = wel ? ST_ADDR : ST_IGNORE;
                default:            disp_state = ST_IGNORE;
            endcase
        end
        case (state)
            ST_IDLE: if (csb_fall) state_n = ST_CMD;
            ST_CMD:  if (byte_done) state_n = disp_state;
            ST_ADDR: if (rise && addr_cnt == 5'd23) state_n = addr_is_read ? ST_RD_DATA : ST_WR_DATA;
            default: ;
        endcase
        if (csb_rise) state_n = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (state == ST_WR_DATA && byte_done) mem[addr] <= mem[addr] & rx_byte;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spi_do       <= 1'b1;
            wip          <= 1'b0;
            wel          <= 1'b0;
            cmd          <= 8'h00;
            cmd_strobe   <= 1'b0;
            bit_cnt      <= 3'd0;
            shift_in     <= 7'd0;
            addr_cnt     <= 5'd0;
            addr         <= '0;
            tx_sr        <= 8'hFF;
            tx_cnt       <= 3'd0;
            resp_idx     <= 2'd0;
            resp_status  <= 1'b0;
            addr_is_read <= 1'b0;
            pend_wren    <= 1'b0;
            pend_wrdi    <= 1'b0;
            pp_written   <= 1'b0;
            busy_cnt     <= '0;
        end else begin
            cmd_strobe <= 1'b0;
            if (csb_fall) begin
                bit_cnt    <= 3'd0;
                addr_cnt   <= 5'd0;
                pend_wren  <= 1'b0;
                pend_wrdi  <= 1'b0;
                pp_written <= 1'b0;
                spi_do     <= 1'b1;
            end
            if (rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                shift_in <= rx_byte[6:0];
            end
            case (state)
                ST_CMD: if (byte_done) begin
                    cmd          <= rx_byte;
                    cmd_strobe   <= 1'b1;
                    pend_wren    <= !wip && rx_byte == CMD_WREN;
                    pend_wrdi    <= !wip && rx_byte == CMD_WRDI;
                    addr_is_read <= rx_byte == CMD_READ;
                    resp_status  <= rx_byte == CMD_RDSR;
                    resp_idx     <= 2'd1;
                    tx_cnt       <= 3'd0;
                    tx_sr        <= (rx_byte == CMD_RDSR) ? status_byte(wel, wip) : id_byte(2'd0);
                end
                ST_ADDR: if (rise) begin
                    addr     <= addr_shift;
                    addr_cnt <= addr_cnt + 5'd1;
                    if (addr_cnt == 5'd23) begin
                        tx_sr  <= mem[addr_shift];
                        tx_cnt <= 3'd0;
                    end
                end
                ST_RD_DATA, ST_RESP: if (fall) begin
                    spi_do <= tx_sr[7];
                    tx_cnt <= tx_cnt + 3'd1;
                    if (tx_cnt != 3'd7) begin
                        tx_sr <= {tx_sr[6:0], 1'b1};
                    end else if (state == ST_RD_DATA) begin
                        addr  <= addr_inc;
                        tx_sr <= mem[addr_inc];
                    end else if (resp_status) begin
                        tx_sr <= status_byte(wel, wip);
                    end else begin
                        tx_sr <= id_byte(resp_idx);
                        if (resp_idx != 2'd3) resp_idx <= resp_idx + 2'd1;
                    end
                end
                // Page program wraps inside the current 256-byte page.
                ST_WR_DATA: if (byte_done) begin
                    addr[7:0]  <= addr[7:0] + 8'd1;
                    pp_written <= 1'b1;
                end
                ST_IGNORE: if (rise) begin
                    pend_wren <= 1'b0;
                    pend_wrdi <= 1'b0;
                end
                default: ;
            endcase
            if (csb_rise) begin
                spi_do <= 1'b1;
                if (state == ST_IGNORE && pend_wren) wel <= 1'b1;
                if (state == ST_IGNORE && pend_wrdi) wel <= 1'b0;
                if (state == ST_WR_DATA && pp_written) begin
                    wip      <= 1'b1;
                    busy_cnt <= BW'(BUSY_CYCLES);
                end
            end
            if (wip) begin
                busy_cnt <= busy_cnt - 1'b1;
                if (busy_cnt == BW'(1)) begin
                    wip <= 1'b0;
                    wel <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed-plus-random SPI master driving the flash model against a transaction-level reference.
module tb_spi_flash_responder;

    localparam int          AW    = 10;
    localparam int          DEPTH = 1 << AW;
    localparam int          BUSY  = 1500;
    localparam int          HALF  = 8;
    localparam logic [23:0] JID   = 24'hEF4018;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       spi_csb = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_di = 1'b0;
    logic       spi_do, wip, wel, cmd_strobe;
    logic [7:0] cmd;

    spi_flash_responder #(.JEDEC_ID(JID), .AW(AW), .BUSY_CYCLES(BUSY)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_csb    (spi_csb),
        .spi_clk    (spi_clk),
        .spi_di     (spi_di),
        .spi_do     (spi_do),
        .wip        (wip),
        .wel        (wel),
        .cmd        (cmd),
        .cmd_strobe (cmd_strobe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    always @(posedge clk) if (cmd_strobe) strobe_cnt <= strobe_cnt + 1;

    logic [7:0] mem_m [DEPTH];
    logic       wel_m = 1'b0;
    logic       wip_m = 1'b0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] expq[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        spi_di = b;
        tick(HALF);
        r = spi_do;
        spi_clk = 1'b1;
        tick(HALF);
        spi_clk = 1'b0;
    endtask

    task automatic cs_begin();
        spi_csb = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_end();
        tick(HALF);
        spi_csb = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic send_byte(input logic [7:0] t, output logic [7:0] r);
        logic b;
        for (int k = 7; k >= 0; k--) begin
            bit_xfer(t[k], b);
            r[k] = b;
        end
    endtask

    task automatic run_txn();
        logic [7:0] r;
        rxq.delete();
        cs_begin();
        foreach (txq[i]) begin
            send_byte(txq[i], r);
            rxq.push_back(r);
        end
        cs_end();
    endtask

    // Whole-transaction reference: expected MISO bytes plus state effects.
    task automatic model_txn();
        logic [7:0]  op;
        logic [23:0] id;
        int          n, a;
        id = JID;
        op = txq[0];
        n  = txq.size();
        expq.delete();
        for (int i = 0; i < n; i++) expq.push_back(8'hFF);
        if (wip_m && op != 8'h05) return;
        case (op)
            8'h9F: for (int i = 1; i < n; i++) expq[i] = (i <= 3) ? id[8*(3-i) +: 8] : 8'hFF;
            8'h05: for (int i = 1; i < n; i++) expq[i] = {6'b0, wel_m, wip_m};
            8'h06: if (n == 1) wel_m = 1'b1;
            8'h04: if (n == 1) wel_m = 1'b0;
            8'h03: if (n >= 4) begin
                a = int'({txq[1], txq[2], txq[3]}) % DEPTH;
                for (int i = 4; i < n; i++) begin
                    expq[i] = mem_m[a];
                    a = (a + 1) % DEPTH;
                end
            end
            8'h02: if (wel_m && n >= 5) begin
                a = int'({txq[1], txq[2], txq[3]}) % DEPTH;
                for (int i = 4; i < n; i++) begin
                    mem_m[a] = mem_m[a] & txq[i];
                    a = (a & ~255) | ((a + 1) & 255);
                end
                wip_m = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic txn(input string tag);
        model_txn();
        run_txn();
        for (int i = 0; i < rxq.size(); i++) check($sformatf("%s rx%0d", tag, i), rxq[i], expq[i]);
        check({tag, " cmd"}, cmd, txq[0]);
        check({tag, " do_idle"}, spi_do, 1'b1);
    endtask

    task automatic wait_busy();
        tick(BUSY + 50);
        if (wip_m) begin
            wip_m = 1'b0;
            wel_m = 1'b0;
        end
    endtask

    initial begin
        int          s0;
        int unsigned a24;
        int          len;
        logic [7:0]  r;
        logic        b;

        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hFF;
        tick(4);
        check("rst spi_do", spi_do, 1'b1);
        check("rst wip", wip, 1'b0);
        check("rst wel", wel, 1'b0);
        check("rst cmd", cmd, 8'h00);
        check("rst strobe", cmd_strobe, 1'b0);
        reset = 1'b1;
        tick(8);

        s0 = strobe_cnt;
        txq = '{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("rdid");
        check("rdid strobes", strobe_cnt - s0, 1);

        txq = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
        txn("read_erased");

        txq = '{8'h02, 8'h00, 8'h00, 8'h10, 8'hA5};
        txn("pp_gated");
        check("pp_gated wip", wip, 1'b0);
        txq = '{8'h05, 8'h00};
        txn("rdsr_gated");
        txq = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00};
        txn("read_gated");

        txq = '{8'h06};
        txn("wren");
        check("wren wel", wel, 1'b1);
        txq = '{8'h02, 8'h00, 8'h00, 8'hFF, 8'h5A, 8'h3C};
        txn("pp_wrap");
        txq = '{8'h05, 8'h00, 8'h00};
        txn("rdsr_busy");
        txq = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("read_locked");
        check("busy wip", wip, 1'b1);
        check("busy wel", wel, 1'b1);
        wait_busy();
        check("done wip", wip, 1'b0);
        check("done wel", wel, 1'b0);
        txq = '{8'h05, 8'h00};
        txn("rdsr_idle");
        txq = '{8'h03, 8'h00, 8'h00, 8'hFF, 8'h00};
        txn("read_ff");
        txq = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("read_00");
        txq = '{8'h03, 8'h00, 8'h03, 8'hFF, 8'h00, 8'h00};
        txn("read_arraywrap");

        // Partial WREN: only five bits clocked before deselect.
        cs_begin();
        for (int k = 0; k < 5; k++) bit_xfer(1'b0, b);
        cs_end();
        check("abort wel", wel, 1'b0);
        txq = '{8'h06, 8'h00};
        txn("wren_9plus");
        check("wren_long wel", wel, 1'b0);
        txq = '{8'h06};
        txn("wren2");
        txq = '{8'h04};
        txn("wrdi");
        check("wrdi wel", wel, 1'b0);

        for (int it = 0; it < 4; it++) begin
            txq = '{8'h06};
            txn($sformatf("r%0d wren", it));
            a24 = $urandom;
            len = $urandom_range(1, 4);
            txq = '{8'h02, a24[23:16], a24[15:8], a24[7:0]};
            for (int j = 0; j < len; j++) txq.push_back(8'($urandom));
            txn($sformatf("r%0d pp", it));
            check($sformatf("r%0d wip", it), wip, 1'b1);
            wait_busy();
            check($sformatf("r%0d wip_end", it), wip, 1'b0);
            txq = '{8'h03, a24[23:16], a24[15:8], a24[7:0]};
            for (int j = 0; j <= len; j++) txq.push_back(8'h00);
            txn($sformatf("r%0d read", it));
        end

        txq = '{8'h06};
        txn("wren3");
        cs_begin();
        send_byte(8'h03, r);
        send_byte(8'h00, r);
        send_byte(8'h00, r);
        send_byte(8'hFF, r);
        for (int k = 0; k < 4; k++) bit_xfer(1'b0, b);
        reset = 1'b0;
        tick(2);
        check("midrst spi_do", spi_do, 1'b1);
        check("midrst wel", wel, 1'b0);
        check("midrst wip", wip, 1'b0);
        check("midrst cmd", cmd, 8'h00);
        spi_csb = 1'b1;
        tick(4);
        reset = 1'b1;
        wel_m = 1'b0;
        wip_m = 1'b0;
        tick(16);
        txq = '{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("rdid_after_rst");
        txq = '{8'h03, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        txn("read_kept");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
